// File: rtl/rr_merge_pkg.sv
// rr_merge_pkg: shared FSM state type and synchronizer depth for rr_merge_arbiter.
package rr_merge_pkg;
    typedef enum logic [1:0] {IDLE, REQ, ACK, RTZ} rr_state_t;
    localparam int SYNC_DEPTH = 2;
endpackage

// File: rtl/rr_pick.sv
// rr_pick: combinational round-robin picker; first set request at or after i_ptr, with wrap-around.
module rr_pick
    import rr_merge_pkg::*;
#(
    parameter  int size  = 2,
    localparam int IDX_W = $clog2(size)
) (
    input  logic [size-1:0]  i_req,
    input  logic [IDX_W-1:0] i_ptr,
    output logic             o_valid,
    output logic [IDX_W-1:0] o_idx
);
    logic [IDX_W:0]   w_sum;
    logic [IDX_W-1:0] w_pos;
    // Scan from the farthest offset down so the nearest set bit to i_ptr wins.
    always_comb begin
        o_valid = 1'b0;
        o_idx   = '0;
        w_sum   = '0;
        w_pos   = '0;
        for (int k = size - 1; k >= 0; k--) begin
            w_sum = {1'b0, i_ptr} + (IDX_W + 1)'(k);
            w_pos = IDX_W'(w_sum >= (IDX_W + 1)'(size) ? w_sum - (IDX_W + 1)'(size) : w_sum);
            if (i_req[w_pos]) begin
                o_valid = 1'b1;
                o_idx   = w_pos;
            end
        end
    end
endmodule

// File: rtl/rr_merge_arbiter.sv
// rr_merge_arbiter: round-robin merge of size 4-phase requesters onto one downstream channel.
// Define RR_MERGE_SYNC_EN to pass req_in and ack_out through 2-flop synchronizers.
module rr_merge_arbiter
    import rr_merge_pkg::*;
#(
    parameter  int size  = 2,
    localparam int IDX_W = $clog2(size)
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic [size-1:0]  i_req_in,
    output logic [size-1:0]  o_ack_in,
    output logic             o_req_out,
    input  logic             i_ack_out,
    output logic [IDX_W-1:0] o_grant_idx,
    output logic             o_busy
);
    rr_state_t        r_state, w_state_nx;
    logic [IDX_W-1:0] r_ptr, w_ptr_nx, r_grant, w_grant_nx, w_pick_idx;
    logic [size-1:0]  r_ack_in, w_ack_in_nx, w_req;
    logic             r_req_out, w_req_out_nx, w_pick_valid, w_ack;

`ifdef RR_MERGE_SYNC_EN
    logic [SYNC_DEPTH-1:0][size-1:0] r_req_sync;
    logic [SYNC_DEPTH-1:0]           r_ack_sync;
    always_ff @(posedge i_clk) begin
        if (!i_rst) begin
            r_req_sync <= '0;
            r_ack_sync <= '0;
        end else begin
            r_req_sync <= {r_req_sync[SYNC_DEPTH-2:0], i_req_in};
            r_ack_sync <= {r_ack_sync[SYNC_DEPTH-2:0], i_ack_out};
        end
    end
    assign w_req = r_req_sync[SYNC_DEPTH-1];
    assign w_ack = r_ack_sync[SYNC_DEPTH-1];
`else
    assign w_req = i_req_in;
    assign w_ack = i_ack_out;
`endif

    rr_pick #(.size(size)) u_pick (
        .i_req   (w_req),
        .i_ptr   (r_ptr),
        .o_valid (w_pick_valid),
        .o_idx   (w_pick_idx)
    );

    always_comb begin
        w_state_nx   = r_state;
        w_ptr_nx     = r_ptr;
        w_grant_nx   = r_grant;
        w_req_out_nx = r_req_out;
        w_ack_in_nx  = r_ack_in;
        case (r_state)
            IDLE: if (w_pick_valid) begin
                w_grant_nx   = w_pick_idx;
                w_req_out_nx = 1'b1;
                w_state_nx   = REQ;
            end
            REQ: if (w_ack) begin
                w_ack_in_nx = {{(size - 1){1'b0}}, 1'b1} << r_grant;
                w_state_nx  = ACK;
            end
            ACK: if (!w_req[r_grant]) begin
                w_req_out_nx = 1'b0;
                w_state_nx   = RTZ;
            end
            RTZ: if (!w_ack) begin
                w_ack_in_nx = '0;
                w_ptr_nx    = (r_grant == IDX_W'(size - 1)) ? '0 : r_grant + 1'b1;
                w_state_nx  = IDLE;
            end
            default: w_state_nx = IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst) begin
            r_state   <= IDLE;
            r_ptr     <= '0;
            r_grant   <= '0;
            r_req_out <= 1'b0;
            r_ack_in  <= '0;
        end else begin
            r_state   <= w_state_nx;
            r_ptr     <= w_ptr_nx;
            r_grant   <= w_grant_nx;
            r_req_out <= w_req_out_nx;
            r_ack_in  <= w_ack_in_nx;
        end
    end

    assign o_ack_in    = r_ack_in;
    assign o_req_out   = r_req_out;
    assign o_grant_idx = r_grant;
    assign o_busy      = (r_state != IDLE);
endmodule

// File: doc/rr_merge_arbiter.md
Name: rr_merge_arbiter

Overview:
- Clocked 4-phase handshake arbiter. It merges `size` requester channels (req_in/ack_in pairs) onto one shared downstream channel (req_out/ack_out).
- It is the counterpart of the fork stage: the fork splits one token to N branches, and this block lets N branches share one resource, one transaction at a time.
- Requesters are served in round-robin order. A grant is held for the full 4-phase cycle.

Parameters:
- size, 2, number of requester channels (>= 2).
- IDX_W, $clog2(size), width of the grant index (derived localparam, not overridable).

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst  input  1  synchronous active-low reset; sampled on clk rising edge.
- req_in  input  size  request from requester i (4-phase).
- ack_in  output  size  acknowledge to requester i; one-hot or zero.
- req_out  output  1  request to shared downstream resource.
- ack_out  input  1  acknowledge from downstream resource.
- grant_idx  output  IDX_W  index of current/last granted requester.
- busy  output  1  high whenever state != IDLE.

Behaviour:
- Reset (rst==0 at edge): state=IDLE, req_out=0, ack_in=0, grant_idx=0, busy=0, rr pointer=0 (requester 0 has highest priority first). Reset mid-transaction aborts immediately with these values; no handshake completion is attempted.
- All outputs are registered. No combinational path from any input to any output.
- FSM states:
  - IDLE:
    - If any req_in[i]=1, pick the first set bit scanning from the rr pointer upward with wrap-around.
    - At that edge: grant_idx=i, req_out=1, go to REQ.
    - Latency: req_in rise sampled at edge k gives req_out=1 after edge k.
  - REQ: wait for ack_out=1. Then ack_in[grant_idx]=1 and go to ACK.
  - ACK: wait for req_in[grant_idx]=0. Then req_out=0 and go to RTZ.
  - RTZ:
    - Wait for ack_out=0. Then ack_in[grant_idx]=0, rr pointer=(grant_idx+1) mod size, go to IDLE.
    - Wrap: pointer at size-1 goes to 0.
- Arbitration happens only in IDLE. Requests that arrive or change during REQ/ACK/RTZ have no effect until IDLE.
- Minimum transaction: 4 edges with an instantly-responding peer. A new grant occurs on the edge after returning to IDLE, so there is no back-to-back grant on the RTZ exit edge.
- Simultaneous requests: exactly one granted by round-robin. Others stay pending; their ack_in stays 0.
- Protocol violations:
  - Granted req_in dropping during REQ is ignored; the transaction completes normally.
  - ack_out=1 in IDLE is ignored.
  - No error flag.
- Outputs ack_in bits other than grant_idx are always 0.

Optional Feature:
- Macro: RR_MERGE_SYNC_EN.
- Defined:
  - req_in (each bit) and ack_out pass through 2-flop synchronizers before the FSM.
  - All response latencies increase by 2 edges.
  - Reset clears the synchronizer flops to 0.
- Undefined: inputs are used directly and are assumed synchronous to clk.

Decomposition:
- Package rr_merge_pkg holds:
  - typedef enum logic [1:0] {IDLE, REQ, ACK, RTZ} rr_state_t;
  - the synchronizer depth constant (2).
- One sub-module, rr_pick. It is a combinational round-robin priority picker with:
  - inputs: req vector and pointer;
  - outputs: valid and index.
- The top-level FSM instantiates rr_pick once.

Test Plan (size=2 unless noted):
1. Reset: rst=0 for 2 edges with req_in=2'b11 -> req_out=0, ack_in=2'b00, busy=0, grant_idx=0 throughout.
2. Single full cycle, requester 1 only:
   - Stimulus: req_in=2'b10, then ack_out=1, then req_in=2'b00, then ack_out=0.
   - Response: req_out rises 1 edge after req_in, then ack_in=2'b10, then req_out=0, then ack_in=2'b00, then busy=0.
3. Fairness: req_in held at 2'b11 for 4 transactions -> grant_idx sequence 0,1,0,1.
4. Late arrival: req_in[1] raised during requester 0's ACK state -> no change to ack_in. Requester 1 is granted on the first edge after IDLE is reached.
5. Reset mid-transaction: rst=0 while in ACK with ack_in=2'b01 -> next edge gives req_out=0, ack_in=2'b00, and the next grant with req_in=2'b11 goes to requester 0.
6. With RR_MERGE_SYNC_EN and size=3, single requester 2:
   - req_out rises 3 edges after req_in[2] (vs 1 edge without the macro).
   - Full cycle completes; grant_idx=2, then the pointer wraps to 0.
